branch_predictor: RTL and testbench

Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It produces the `pred_taken` / `pred_pc` pair that travels down the pipeline with each instruction. Lookup is combinational on the fetch PC. The execute-2 stage returns the resolved outcome through a registered update port, which trains the counters and allocates or replaces entries.

---
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup on pc_f, trained by the E2 update port.
// Optional perf counters are built only when BP_PERF_CNT_EN is defined; otherwise both perf outputs are tied to zero.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    output logic [31:0] pred_pc_f,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_is_jump,
    input  logic        upd_mispredict,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic               jump_q   [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Lookup reads stored state only, so a same-cycle update is not bypassed.
    assign pred_taken_f = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
    assign pred_pc_f    = pred_taken_f ? target_q[f_idx] : pc_f + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                end else begin
                    if (ctr_q[u_idx] != 2'b00) ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end

    // Payload fields carry no reset; they are meaningful only while valid is set.
    always_ff @(posedge clk) begin
        if (!rst && upd_en && upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
            jump_q[u_idx]   <= upd_is_jump;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q    <= 32'h0;
            mispredicts_q <= 32'h0;
        end else if (upd_en) begin
            branches_q <= branches_q + 32'd1;
            if (upd_mispredict) mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign perf_branches    = branches_q;
    assign perf_mispredicts = mispredicts_q;
    assign unused_bits      = ^{pc_f[1:0], upd_pc[1:0]};
`else
    logic unused_bits;

    assign perf_branches    = 32'h0;
    assign perf_mispredicts = 32'h0;
    assign unused_bits      = ^{pc_f[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a table-level model checked every cycle, plus directed literal expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_f = 32'h100;
    logic        pred_taken_f;
    logic [31:0] pred_pc_f;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_is_jump = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_pc_f(pred_pc_f),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_mispredict(upd_mispredict),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: each slot remembers the full PC that owns it and a counter as a plain integer 0..3.
    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] tgt;
        int          ctr;
        bit          j;
    } ent_t;
    ent_t        m [16];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit owns(input int s, input logic [31:0] pc);
        return m[s].v && ((m[s].pc >> 6) == (pc >> 6));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m[i].v = 1'b0;
                m[i].ctr = 1;
            end
            m_br = 32'h0;
            m_mis = 32'h0;
        end else if (upd_en) begin
            int s;
            s = slot_of(upd_pc);
            m_br = m_br + 32'd1;
            if (upd_mispredict) m_mis = m_mis + 32'd1;
            if (owns(s, upd_pc)) begin
                if (upd_taken) begin
                    m[s].ctr = (m[s].ctr + 1 > 3) ? 3 : m[s].ctr + 1;
                    m[s].tgt = upd_target;
                    m[s].j = upd_is_jump;
                end else begin
                    m[s].ctr = (m[s].ctr - 1 < 0) ? 0 : m[s].ctr - 1;
                end
            end else if (upd_taken) begin
                m[s].v = 1'b1;
                m[s].pc = upd_pc;
                m[s].tgt = upd_target;
                m[s].ctr = 2;
                m[s].j = upd_is_jump;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int s;
            bit et;
            logic [31:0] ep;
            s = slot_of(pc_f);
            et = owns(s, pc_f) && (m[s].j || m[s].ctr >= 2);
            ep = et ? m[s].tgt : pc_f + 32'd4;
            check("model_taken", {31'h0, pred_taken_f}, {31'h0, et});
            check("model_pc", pred_pc_f, ep);
`ifdef BP_PERF_CNT_EN
            check("model_perf_br", perf_branches, m_br);
            check("model_perf_mis", perf_mispredicts, m_mis);
`else
            check("perf_br_zero", perf_branches, 32'h0);
            check("perf_mis_zero", perf_mispredicts, 32'h0);
`endif
        end
    end

    task automatic cyc(input logic en, input logic [31:0] upc, input logic tk,
                       input logic [31:0] tg, input logic jp, input logic mis,
                       input logic [31:0] look);
        @(posedge clk);
        #1;
        upd_en = en;
        upd_pc = upc;
        upd_taken = tk;
        upd_target = tg;
        upd_is_jump = jp;
        upd_mispredict = mis;
        pc_f = look;
    endtask

    task automatic idle(input logic [31:0] look);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, look);
    endtask

    task automatic expect_lit(input string name, input logic t, input logic [31:0] p);
        @(negedge clk);
        check({name, "_taken"}, {31'h0, pred_taken_f}, {31'h0, t});
        check({name, "_pc"}, pred_pc_f, p);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state and index sweep.
        expect_lit("reset_0x100", 1'b0, 32'h104);
        for (int i = 0; i < 16; i++) begin
            idle(32'h100 + 32'(i) * 32'd4);
            expect_lit("reset_sweep", 1'b0, 32'h104 + 32'(i) * 32'd4);
        end

        // Allocate; the update cycle itself still sees the old contents.
        cyc(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h100);
        expect_lit("alloc_same_cycle", 1'b0, 32'h104);
        idle(32'h100);
        expect_lit("alloc_next", 1'b1, 32'h80);

        // Hysteresis: 10 -> 01 -> 00, then 01, then 10.
        cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
        idle(32'h100);
        expect_lit("hyst_two_nt", 1'b0, 32'h104);
        cyc(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h100);
        idle(32'h100);
        expect_lit("hyst_one_t", 1'b0, 32'h104);
        cyc(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h100);
        idle(32'h100);
        expect_lit("hyst_two_t", 1'b1, 32'h80);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
        idle(32'h100);
        expect_lit("hyst_sat_nt", 1'b1, 32'h80);

        // Aliasing at index 0.
        idle(32'h140);
        expect_lit("alias_miss", 1'b0, 32'h144);
        cyc(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 1'b0, 32'h140);
        idle(32'h140);
        expect_lit("alias_new", 1'b1, 32'h200);
        idle(32'h100);
        expect_lit("alias_evicted", 1'b0, 32'h104);
        cyc(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0, 32'h180);
        idle(32'h140);
        expect_lit("alias_nt_noalloc", 1'b1, 32'h200);
        idle(32'h180);
        expect_lit("alias_nt_miss", 1'b0, 32'h184);

        // Jumps ignore the counter.
        cyc(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 1'b0, 32'h300);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300);
        idle(32'h300);
        expect_lit("jump_sticky", 1'b1, 32'h400);

        // Reset wins over a simultaneous update.
        @(posedge clk);
        #1;
        rst = 1'b1;
        upd_en = 1'b1;
        upd_pc = 32'h500;
        upd_taken = 1'b1;
        upd_target = 32'h600;
        upd_is_jump = 1'b1;
        upd_mispredict = 1'b1;
        idle(32'h300);
        rst = 1'b0;
        expect_lit("rst_clears", 1'b0, 32'h304);
        idle(32'h500);
        expect_lit("rst_drops_upd", 1'b0, 32'h504);
        check("perf_br_after_rst", perf_branches, 32'h0);

        // Perf counters: 5 updates, 2 flagged mispredicts.
        cyc(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1, 32'h10);
        cyc(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10);
        cyc(1'b1, 32'h18, 1'b1, 32'h30, 1'b0, 1'b0, 32'h10);
        cyc(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
        cyc(1'b1, 32'h1c, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10);
        idle(32'h18);
        @(negedge clk);
`ifdef BP_PERF_CNT_EN
        check("perf_branches", perf_branches, 32'd5);
        check("perf_mispredicts", perf_mispredicts, 32'd2);
`else
        check("perf_branches_off", perf_branches, 32'h0);
        check("perf_mispredicts_off", perf_mispredicts, 32'h0);
`endif

        // Mixed traffic over a few aliasing PCs, checked by the model each cycle.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] upc;
            logic [31:0] look;
            upc  = 32'h100 + 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 3)) * 32'd4;
            look = 32'h100 + 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 3)) * 32'd4;
            cyc(1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)) * 32'd4, 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), look);
        end
        idle(32'h100);
        @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
